load_use_scoreboard: RTL and testbench
======================================

# load_use_scoreboard

Tracks every in-flight load destination register and raises a stall when an instruction in ID needs a load result that cannot yet be forwarded. It is the producer-side complement to the EX forwarding unit. The forwarding unit resolves ALU results from EX/MEM and MEM/WB. This block holds decode until a load's data has reached MEM/WB, so the forwarding unit can then supply it with select 01. It sits beside the ID stage, and its `Stall` output gates the PC, IF/ID and ID/EX bubble insertion.

## Interface
- `NREGS`, 32: architectural registers; register 0 is hard-wired zero.
- `CNT_W`, 16: width of the stall-cycle counter.

- `CLK`  in  1  pipeline clock, all state on rising edge.
- `RST_N`  in  1  synchronous, active-low reset.
- `ID_Valid`  in  1  ID holds a real (non-bubble) instruction.
- `IF_IDRegisterRs`, `IF_IDRegisterRt`  in  5 each  source fields of the instruction in ID.
- `ID_UsesRs`, `ID_UsesRt`  in  1 each  instruction actually reads that source.
- `ID_MemRead`, `ID_RegWrite`  in  1 each  instruction in ID is a load writing a register.
- `ID_RegisterRd`  in  5  destination of the instruction in ID.
- `EX_MEMMemRead`  in  1  instruction in MEM is a load.
- `EX_MEMRegisterRd`  in  5  its destination.
- `MEM_Ready`  in  1  data memory returns load data this cycle; 0 freezes the whole pipeline.
- `EX_Flush`  in  1  instruction in EX is squashed (branch resolve).
- `ID_EXMemRead`, `ID_EXRegisterRd`  in  1 / 5  squashed instruction's load flag and destination.
- `Stall`  out  1  hold PC and IF/ID; insert bubble into ID/EX.
- `LoadPending`  out  NREGS  registered pending-load bitmap (debug/verification).
- `StallCount`  out  CNT_W  saturating count of cycles with `Stall`=1.

## Operation
- State: `pend[NREGS-1:0]` and `cnt[CNT_W-1:0]`. `pend[0]` is constant 0.
- Issue: `set = ID_Valid & ID_MemRead & ID_RegWrite & (ID_RegisterRd!=0) & !Stall & MEM_Ready`. This sets `pend[ID_RegisterRd]`.
- Complete: `clr = EX_MEMMemRead & MEM_Ready & (EX_MEMRegisterRd!=0)`. This clears `pend[EX_MEMRegisterRd]`. The data is captured into MEM/WB at this edge.
- Squash: `sq = EX_Flush & ID_EXMemRead & (ID_EXRegisterRd!=0)`. This clears `pend[ID_EXRegisterRd]`.
- Effective pending (combinational): `eff = pend & ~clr_mask`. A load completing this cycle does not stall its consumer.
- `Stall = ID_Valid & ((ID_UsesRs & eff[Rs] & Rs!=0) | (ID_UsesRt & eff[Rt] & Rt!=0))`, plus `!MEM_Ready` (freeze).
- Priority on the same index in one cycle: set wins over clr and sq. This covers a new load to a register whose previous load is completing.
- Counter: `cnt` increments when `Stall`=1 and saturates at all-ones. It never wraps.
- While `MEM_Ready`=0: no set; clr is inactive by definition; sq still applies.

## Timing
- Reset (`RST_N`=0 at an edge): `pend`=0 and `cnt`=0. `LoadPending`=0 and `StallCount`=0 from the next cycle. `Stall` is combinational and reads 0 while `pend`=0 and `MEM_Ready`=1.
- Reset mid-operation discards all pending bits. The pipeline is flushed by the same reset.
- `Stall` is combinational from registered `pend` plus current inputs: zero-cycle latency to ID.
- `LoadPending` and `StallCount` update one cycle after the causing event.
- Classic load-use with `MEM_Ready`=1: exactly 1 stall cycle. Each extra cycle with `MEM_Ready`=0 adds 1 cycle.
- `Stall` does not depend on its own registered effect: `set` uses `Stall` combinationally, with no loop through `pend`.

## Structure
- Shared package `pipe_pkg`: `REG_W=5`, `NREGS=32`, `REG_ZERO=5'd0`, and the forwarding select constants `FWD_NONE=2'b00`, `FWD_WB=2'b01`, `FWD_MEM=2'b10`. These are shared with the forwarding unit.
- One natural sub-module, `reg_decoder`: 5-to-32 one-hot decoder with enable. It is instantiated three times, for the set, clr and sq masks.

## Test plan
- Reset, then load `$5` issue, then `add` using `$5` in the next cycle with `MEM_Ready`=1. Required: `Stall`=1 for exactly one cycle. `LoadPending[5]` goes 1 then 0. `StallCount`=1.
- Load `$5` with `MEM_Ready`=0 for 3 cycles while the consumer waits in ID. Required: `Stall`=1 for 4 cycles. `pend[5]` is held and then cleared on the ready cycle. `StallCount`=4.
- Load to `$0`, consumer reads `$0`. Required: `LoadPending`=0 and `Stall` never asserts.
- Load `$7` in MEM completing while a new load `$7` issues in ID in the same cycle. Required: `LoadPending[7]` stays 1.
- Load `$9` in EX with `EX_Flush`=1. Required: `pend[9]` is cleared next cycle, and a consumer of `$9` is not stalled afterward.
- `CNT_W`=4, hold `MEM_Ready`=0 for 20 cycles. Required: `StallCount` saturates at 15. Then assert `RST_N`=0 for one edge. Required: `StallCount`=0 and `LoadPending`=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Pipeline-wide register-index types and forwarding select encodings,
// shared by the load-use scoreboard and the EX forwarding unit.
package pipe_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned NREGS = 32;

  typedef logic [REG_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/reg_decoder.sv
// Register index to one-hot mask decoder with enable.
module reg_decoder
  import pipe_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         en,
  input  reg_idx_t     idx,
  output logic [N-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (en && (idx == REG_W'(i))) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/load_use_scoreboard.sv
// Tracks in-flight load destinations and stalls ID until a load's data can be
// forwarded from MEM/WB; also counts stall cycles (saturating).
module load_use_scoreboard
  import pipe_pkg::*;
#(
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ID_Valid,
  input  reg_idx_t         IF_IDRegisterRs,
  input  reg_idx_t         IF_IDRegisterRt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_MemRead,
  input  logic             ID_RegWrite,
  input  reg_idx_t         ID_RegisterRd,
  input  logic             EX_MEMMemRead,
  input  reg_idx_t         EX_MEMRegisterRd,
  input  logic             MEM_Ready,
  input  logic             EX_Flush,
  input  logic             ID_EXMemRead,
  input  reg_idx_t         ID_EXRegisterRd,
  output logic             Stall,
  output logic [NREGS-1:0] LoadPending,
  output logic [CNT_W-1:0] StallCount
);

  logic [NREGS-1:0] pend, pend_next, eff;
  logic [NREGS-1:0] set_mask, clr_mask, sq_mask;
  logic [CNT_W-1:0] cnt;
  logic             set_en, clr_en, sq_en;
  logic             rs_hit, rt_hit;

  // set_en depends on Stall, and Stall only on clr_mask, so there is no loop
  assign clr_en = EX_MEMMemRead & MEM_Ready & (EX_MEMRegisterRd != REG_ZERO);
  assign sq_en  = EX_Flush & ID_EXMemRead & (ID_EXRegisterRd != REG_ZERO);
  assign set_en = ID_Valid & ID_MemRead & ID_RegWrite &
                  (ID_RegisterRd != REG_ZERO) & ~Stall & MEM_Ready;

  reg_decoder #(.N(NREGS)) u_set_dec (
    .en     (set_en),
    .idx    (ID_RegisterRd),
    .onehot (set_mask)
  );

  reg_decoder #(.N(NREGS)) u_clr_dec (
    .en     (clr_en),
    .idx    (EX_MEMRegisterRd),
    .onehot (clr_mask)
  );

  reg_decoder #(.N(NREGS)) u_sq_dec (
    .en     (sq_en),
    .idx    (ID_EXRegisterRd),
    .onehot (sq_mask)
  );

  // A load completing this cycle is forwardable next cycle: no stall for it
  assign eff    = pend & ~clr_mask;
  assign rs_hit = ID_UsesRs & eff[IF_IDRegisterRs] & (IF_IDRegisterRs != REG_ZERO);
  assign rt_hit = ID_UsesRt & eff[IF_IDRegisterRt] & (IF_IDRegisterRt != REG_ZERO);
  assign Stall  = (ID_Valid & (rs_hit | rt_hit)) | ~MEM_Ready;

  always_comb begin
    pend_next    = (pend & ~clr_mask & ~sq_mask) | set_mask;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pend <= '0;
      cnt  <= '0;
    end else begin
      pend <= pend_next;
      if (Stall && (cnt != '1)) cnt <= cnt + 1'b1;
    end
  end

  assign LoadPending = pend;
  assign StallCount  = cnt;

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Randomized and directed bench: a bit-array reference model predicts each
// cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_load_use_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, uses_rs, uses_rt, id_memread, id_regwrite;
  logic [4:0]  rs, rt, id_rd, exmem_rd, idex_rd;
  logic        exmem_memread, mem_ready, ex_flush, idex_memread;
  logic        stall, stall4;
  logic [31:0] lp, lp4;
  logic [15:0] sc;
  logic [3:0]  sc4;

  typedef struct {
    logic        stall;
    logic [31:0] lp;
    logic [15:0] sc;
    logic [3:0]  sc4;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  logic [31:0] mpend;
  int unsigned mcnt, mcnt4;
  int          total = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  load_use_scoreboard #(.NREGS(32), .CNT_W(16)) dut (
    .CLK(clk), .RST_N(rst_n), .ID_Valid(id_valid),
    .IF_IDRegisterRs(rs), .IF_IDRegisterRt(rt),
    .ID_UsesRs(uses_rs), .ID_UsesRt(uses_rt),
    .ID_MemRead(id_memread), .ID_RegWrite(id_regwrite), .ID_RegisterRd(id_rd),
    .EX_MEMMemRead(exmem_memread), .EX_MEMRegisterRd(exmem_rd),
    .MEM_Ready(mem_ready), .EX_Flush(ex_flush),
    .ID_EXMemRead(idex_memread), .ID_EXRegisterRd(idex_rd),
    .Stall(stall), .LoadPending(lp), .StallCount(sc)
  );

  load_use_scoreboard #(.NREGS(32), .CNT_W(4)) dut4 (
    .CLK(clk), .RST_N(rst_n), .ID_Valid(id_valid),
    .IF_IDRegisterRs(rs), .IF_IDRegisterRt(rt),
    .ID_UsesRs(uses_rs), .ID_UsesRt(uses_rt),
    .ID_MemRead(id_memread), .ID_RegWrite(id_regwrite), .ID_RegisterRd(id_rd),
    .EX_MEMMemRead(exmem_memread), .EX_MEMRegisterRd(exmem_rd),
    .MEM_Ready(mem_ready), .EX_Flush(ex_flush),
    .ID_EXMemRead(idex_memread), .ID_EXRegisterRd(idex_rd),
    .Stall(stall4), .LoadPending(lp4), .StallCount(sc4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit pending_now(input logic [4:0] r, input bit clr);
    return mpend[r] && !(clr && r == exmem_rd) && r != 0;
  endfunction

  // Predict this cycle's outputs, advance the model over the edge, then wait.
  task automatic step();
    exp_t        e;
    bit          clr, st;
    logic [31:0] nxt;
    clr = exmem_memread && mem_ready && exmem_rd != 0;
    st  = !mem_ready || (id_valid && ((uses_rs && pending_now(rs, clr)) ||
                                      (uses_rt && pending_now(rt, clr))));
    e.stall = st;
    e.lp    = mpend;
    e.sc    = mcnt[15:0];
    e.sc4   = mcnt4[3:0];
    q.push_back(e);
    if (!rst_n) begin
      mpend = '0;
      mcnt  = 0;
      mcnt4 = 0;
    end else begin
      nxt = mpend;
      if (ex_flush && idex_memread && idex_rd != 0) nxt[idex_rd] = 1'b0;
      if (clr) nxt[exmem_rd] = 1'b0;
      if (id_valid && id_memread && id_regwrite && id_rd != 0 && !st && mem_ready)
        nxt[id_rd] = 1'b1;
      mpend = nxt;
      if (st) begin
        if (mcnt < 65535) mcnt++;
        if (mcnt4 < 15) mcnt4++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1; id_valid = 1'b0; uses_rs = 1'b0; uses_rt = 1'b0;
    id_memread = 1'b0; id_regwrite = 1'b0; rs = '0; rt = '0; id_rd = '0;
    exmem_memread = 1'b0; exmem_rd = '0; mem_ready = 1'b1;
    ex_flush = 1'b0; idex_memread = 1'b0; idex_rd = '0;
  endtask

  task automatic do_reset();
    idle(); rst_n = 1'b0; step(); idle();
  endtask

  task automatic issue_load(input logic [4:0] rd);
    id_valid = 1'b1; id_memread = 1'b1; id_regwrite = 1'b1; id_rd = rd;
  endtask

  task automatic consumer(input logic [4:0] r);
    id_valid = 1'b1; uses_rs = 1'b1; rs = r; id_memread = 1'b0; id_regwrite = 1'b1; id_rd = 5'd1;
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      me = q.pop_front();
      check("stall", {31'd0, stall}, {31'd0, me.stall});
      check("stall_w4", {31'd0, stall4}, {31'd0, me.stall});
      check("pending", lp, me.lp);
      check("pending_w4", lp4, me.lp);
      check("count", {16'd0, sc}, {16'd0, me.sc});
      check("count_w4", {28'd0, sc4}, {28'd0, me.sc4});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    mpend = '0; mcnt = 0; mcnt4 = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Classic load-use: one stall cycle
    do_reset();
    issue_load(5'd5); step();
    idle(); consumer(5'd5); idex_memread = 1'b1; idex_rd = 5'd5; step();
    check("lu_pend5", {31'd0, lp[5]}, 32'd1);
    idle(); consumer(5'd5); exmem_memread = 1'b1; exmem_rd = 5'd5; step();
    check("lu_count", {16'd0, sc}, 32'd1);
    check("lu_clear", lp, 32'd0);
    idle(); step();

    // Memory not ready for three cycles: four stall cycles
    do_reset();
    issue_load(5'd5); step();
    idle(); consumer(5'd5); step();
    for (int i = 0; i < 3; i++) begin
      idle(); consumer(5'd5); exmem_memread = 1'b1; exmem_rd = 5'd5; mem_ready = 1'b0;
      step();
      check("wait_pend5", {31'd0, lp[5]}, 32'd1);
    end
    idle(); consumer(5'd5); exmem_memread = 1'b1; exmem_rd = 5'd5; step();
    check("wait_count", {16'd0, sc}, 32'd4);
    check("wait_clear", lp, 32'd0);

    // Register zero never tracked
    do_reset();
    issue_load(5'd0); step();
    idle(); consumer(5'd0); uses_rt = 1'b1; rt = 5'd0;
    exmem_memread = 1'b1; exmem_rd = 5'd0; #1;
    check("r0_nostall", {31'd0, stall}, 32'd0);
    step();
    check("r0_pend", lp, 32'd0);

    // Completion and reissue of the same register: set wins
    do_reset();
    issue_load(5'd7); step();
    idle(); step();
    idle(); issue_load(5'd7); exmem_memread = 1'b1; exmem_rd = 5'd7; step();
    check("reissue_pend7", {31'd0, lp[7]}, 32'd1);
    idle(); exmem_memread = 1'b1; exmem_rd = 5'd7; step();

    // Squashed load releases its register
    do_reset();
    issue_load(5'd9); step();
    idle(); ex_flush = 1'b1; idex_memread = 1'b1; idex_rd = 5'd9; step();
    check("flush_pend9", {31'd0, lp[9]}, 32'd0);
    idle(); consumer(5'd9); #1;
    check("flush_nostall", {31'd0, stall}, 32'd0);
    step();

    // Narrow counter saturates, reset clears everything
    do_reset();
    issue_load(5'd3); step();
    for (int i = 0; i < 20; i++) begin
      idle(); mem_ready = 1'b0; step();
    end
    check("sat_w4", {28'd0, sc4}, 32'd15);
    check("sat_w16", {16'd0, sc}, 32'd20);
    idle(); rst_n = 1'b0; step();
    check("rst_count_w4", {28'd0, sc4}, 32'd0);
    check("rst_count", {16'd0, sc}, 32'd0);
    check("rst_pend", lp, 32'd0);

    // Random traffic over a small register window to provoke collisions
    for (int i = 0; i < 2000; i++) begin
      rst_n         = ($urandom_range(0, 99) != 0);
      id_valid      = ($urandom_range(0, 3) != 0);
      uses_rs       = $urandom_range(0, 1) != 0;
      uses_rt       = $urandom_range(0, 1) != 0;
      id_memread    = ($urandom_range(0, 2) == 0);
      id_regwrite   = ($urandom_range(0, 3) != 0);
      rs            = 5'($urandom_range(0, 7));
      rt            = 5'($urandom_range(0, 7));
      id_rd         = 5'($urandom_range(0, 7));
      exmem_memread = ($urandom_range(0, 2) == 0);
      exmem_rd      = 5'($urandom_range(0, 7));
      mem_ready     = ($urandom_range(0, 4) != 0);
      ex_flush      = ($urandom_range(0, 9) == 0);
      idex_memread  = $urandom_range(0, 1) != 0;
      idex_rd       = 5'($urandom_range(0, 7));
      step();
    end

    idle(); step();
    repeat (2) @(negedge clk);
    #1;
    check("queue_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
